// File: rtl/servant_spi_mem_pkg.sv
// Shared definitions for the servant SPI-SRAM memory responder:
// opcodes, FSM encoding and byte-enable helpers.
package servant_spi_mem_pkg;

    localparam logic [7:0] SPI_READ  = 8'h03;
    localparam logic [7:0] SPI_WRITE = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDone
    } state_e;

    function automatic logic [1:0] sel_first(input logic [3:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] sel_count(input logic [3:0] sel);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, sel[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/servant_spi_shifter.sv
// SPI mode-0 bit engine: sclk phase toggle, MSB-first MOSI shift-out and MISO shift-in.
// bit_done_o marks the sclk-high cycle, at whose end MISO is sampled.
module servant_spi_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        bit_done_o,
    output logic [31:0] rx_word_o
);

    logic        phase_q, phase_d;
    logic [31:0] tx_q, tx_d;
    logic [30:0] rx_q, rx_d;

    always_comb begin
        bit_done_o = en_i & phase_q;
        phase_d    = 1'b0;
        tx_d       = tx_q;
        rx_d       = rx_q;
        if (load_i) begin
            // A load always restarts on the sclk-low half of a new bit.
            tx_d = load_data_i;
        end else if (en_i) begin
            phase_d = ~phase_q;
            if (phase_q) tx_d = {tx_q[30:0], 1'b0};
        end
        if (bit_done_o) rx_d = {rx_q[29:0], miso_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            phase_q <= phase_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign sclk_o    = phase_q;
    assign mosi_o    = en_i & tx_q[31];
    assign rx_word_o = {rx_q, miso_i};

endmodule

// File: rtl/servant_spi_mem.sv
// Wishbone memory slave backed by an external serial SRAM: each access becomes one
// SPI transaction (command, address, data) and is acked when the transaction ends.
module servant_spi_mem
    import servant_spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_spi_sclk,
    output logic        o_spi_cs_n,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso
);

    localparam int unsigned     NMax     = 8 + ADDR_W + 32;
    localparam int unsigned     CntW     = $clog2(NMax);
    localparam logic [CntW-1:0] CmdLast  = CntW'(7);
    localparam logic [CntW-1:0] AddrLast = CntW'(8 + ADDR_W - 1);

    state_e state_q, state_d;

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   data_last;
    logic              we_q;
    logic [ADDR_W-3:0] adr_q;
    logic [31:0]       dat_q;
    logic [3:0]        sel_q;
    logic [31:0]       rdt_q, rdt_d;

    logic              start;
    logic              active;
    logic              load;
    logic [31:0]       load_data;
    logic              bit_done;
    logic              sh_mosi;
    logic              sh_sclk;
    logic [31:0]       rx_word;
    logic [ADDR_W-1:0] addr_field;
    logic [31:0]       wr_word;

    // Upper address bits alias freely and the word offset is rebuilt from sel.
    logic unused_adr;
    assign unused_adr = ^{i_wb_adr[31:ADDR_W], i_wb_adr[1:0]};

    always_comb begin
        addr_field = {adr_q, (we_q ? sel_first(sel_q) : 2'b00)};
        wr_word    = dat_q >> {sel_first(sel_q), 3'b000};
        data_last  = AddrLast + (we_q ? CntW'({sel_count(sel_q), 3'b000}) : CntW'(32));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_wb_cyc) begin
                    state_d = (i_wb_we && i_wb_sel == 4'b0000) ? StDone : StCmd;
                end
            end
            StCmd:   if (bit_done && cnt_q == CmdLast)   state_d = StAddr;
            StAddr:  if (bit_done && cnt_q == AddrLast)  state_d = StData;
            StData:  if (bit_done && cnt_q == data_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active    = state_q inside {StCmd, StAddr, StData};
        start     = (state_q == StIdle) && (state_d == StCmd);
        load      = 1'b0;
        load_data = '0;
        if (start) begin
            load      = 1'b1;
            load_data = {(i_wb_we ? SPI_WRITE : SPI_READ), 24'h0};
        end else if (state_q == StCmd && state_d == StAddr) begin
            load      = 1'b1;
            load_data = 32'(addr_field) << (32 - ADDR_W);
        end else if (state_q == StAddr && state_d == StData) begin
            load      = 1'b1;
            load_data = we_q ? bswap32(wr_word) : 32'h0;
        end
        o_wb_ack   = (state_q == StDone);
        o_spi_cs_n = ~active;
        o_spi_sclk = sh_sclk;
        o_spi_mosi = sh_mosi;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start)         cnt_d = '0;
        else if (bit_done) cnt_d = cnt_q + CntW'(1);
        rdt_d = rdt_q;
        // First byte received lands in the low lane.
        if (state_q == StData && !we_q && bit_done) rdt_d = bswap32(rx_word);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rdt_q <= '0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rdt_q <= rdt_d;
            if (start) begin
                we_q  <= i_wb_we;
                adr_q <= i_wb_adr[ADDR_W-1:2];
                dat_q <= i_wb_dat;
                sel_q <= i_wb_sel;
            end
        end
    end

    assign o_wb_rdt = rdt_q;

    servant_spi_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (active),
        .load_i      (load),
        .load_data_i (load_data),
        .miso_i      (i_spi_miso),
        .sclk_o      (sh_sclk),
        .mosi_o      (sh_mosi),
        .bit_done_o  (bit_done),
        .rx_word_o   (rx_word)
    );

endmodule

// File: tb/tb_servant_spi_mem.sv
// Bench for servant_spi_mem with a behavioural 23LC-style SPI SRAM model.
module tb_servant_spi_mem;

    localparam int unsigned ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;

    servant_spi_mem #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb_adr   (wb_adr),
        .i_wb_dat   (wb_dat),
        .i_wb_sel   (wb_sel),
        .i_wb_we    (wb_we),
        .i_wb_cyc   (wb_cyc),
        .o_wb_rdt   (wb_rdt),
        .o_wb_ack   (wb_ack),
        .o_spi_sclk (spi_sclk),
        .o_spi_cs_n (spi_cs_n),
        .o_spi_mosi (spi_mosi),
        .i_spi_miso (spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // ---------------- SPI SRAM model ----------------
    logic [7:0]  mem [0:65535];
    int          bitcnt = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  m_cmd = '0;
    logic [15:0] m_addr = '0;
    logic [7:0]  rd_byte;
    logic [7:0]  obs_q[$];
    logic [7:0]  exp_q[$];
    bit          cs_fell = 0;

    always @(negedge spi_cs_n) begin
        bitcnt  = 0;
        m_cmd   = '0;
        cs_fell = 1;
    end

    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            sh = {sh[6:0], spi_mosi};
            bitcnt++;
            if (bitcnt % 8 == 0) begin
                if (bitcnt == 8) begin
                    m_cmd = sh;
                    obs_q.push_back(sh);
                end else if (bitcnt <= 8 + ADDR_W) begin
                    m_addr = {m_addr[7:0], sh};
                    obs_q.push_back(sh);
                end else begin
                    if (m_cmd == 8'h02) begin
                        mem[m_addr] = sh;
                        obs_q.push_back(sh);
                    end
                    m_addr++;
                end
            end
        end
    end

    always @(negedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            spi_miso = 1'b0;
        end else if (m_cmd == 8'h03 && bitcnt >= 8 + ADDR_W) begin
            rd_byte  = mem[m_addr];
            spi_miso = rd_byte[7 - ((bitcnt - 8 - ADDR_W) % 8)];
        end
    end

    // ---------------- bus monitors ----------------
    int ack_total = 0;
    int hi_run = 0;
    int last_gap = 0;

    always @(negedge clk) begin
        if (wb_ack) ack_total++;
        if (spi_cs_n) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    // Starts at #1 after a posedge; returns #1 after the posedge that opens the ack cycle.
    task automatic wb_access(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we,
                             output int ack_k, output logic [31:0] rdt);
        int c0;
        c0     = cycle;
        ack_k  = -1;
        rdt    = 'x;
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        wb_we  = we;
        wb_cyc = 1'b1;
        for (int i = 0; i < 400 && ack_k < 0; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack) begin
                ack_k = cycle - c0;
                rdt   = wb_rdt;
            end
        end
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb_ack); end
        n_checks++;
        if (wb_rdt !== 32'h0) begin n_fail++; $display("FAIL reset_rdt: got %h want 0", wb_rdt); end
        n_checks++;
        if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        n_checks++;
        if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        n_checks++;
        if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_read(input string nm, input logic [31:0] adr, input logic [7:0] a_hi,
                             input logic [7:0] a_lo, input logic [31:0] exp_rdt);
        int          k;
        logic [31:0] r;
        logic [7:0]  e, o;
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h03);
        exp_q.push_back(a_hi);
        exp_q.push_back(a_lo);
        wb_access(adr, 32'h0, 4'b1111, 1'b0, k, r);
        n_checks++;
        if (k !== 113) begin n_fail++; $display("FAIL %s_ack_cycle: got %0d want 113", nm, k); end
        n_checks++;
        if (r !== exp_rdt) begin n_fail++; $display("FAIL %s_rdt: got %h want %h", nm, r, exp_rdt); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_mosi_len: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s_mosi_byte: got %h want %h", nm, o, e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write(input string nm, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int exp_k);
        int          k;
        logic [31:0] r;
        logic [7:0]  e, o;
        logic [15:0] a;
        obs_q.delete();
        exp_q.delete();
        a = {adr[15:2], 2'b00};
        exp_q.push_back(8'h02);
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                a = {adr[15:2], 2'(i)};
                break;
            end
        end
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) exp_q.push_back(dat[8*i +: 8]);
        end
        wb_access(adr, dat, sel, 1'b1, k, r);
        n_checks++;
        if (k !== exp_k) begin n_fail++; $display("FAIL %s_ack_cycle: got %0d want %0d", nm, k, exp_k); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_mosi_len: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s_mosi_byte: got %h want %h", nm, o, e); end
        end
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                n_checks++;
                if (mem[{adr[15:2], 2'(i)}] !== dat[8*i +: 8]) begin
                    n_fail++;
                    $display("FAIL %s_mem_lane%0d: got %h want %h", nm, i,
                             mem[{adr[15:2], 2'(i)}], dat[8*i +: 8]);
                end
            end
        end
    endtask

    task automatic test_empty_write();
        int          k;
        logic [31:0] r;
        cs_fell = 0;
        wb_access(32'h50, 32'h1234_5678, 4'b0000, 1'b1, k, r);
        n_checks++;
        if (k !== 1) begin n_fail++; $display("FAIL empty_ack_cycle: got %0d want 1", k); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cs_fell !== 1'b0) begin n_fail++; $display("FAIL empty_cs_n: got low want never low"); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h50 + 16'(i)] !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL empty_mem%0d: got %h want %h", i, mem[16'h50 + 16'(i)], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack_total;
        test_write("b2b_wr", 32'h40, 32'hDEAD_BEEF, 4'b1111, 113);
        @(posedge clk);
        #1;
        test_read("b2b_rd", 32'h40, 8'h00, 8'h40, 32'hDEAD_BEEF);
        n_checks++;
        if (!(last_gap >= 2)) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want >=2", last_gap); end
        n_checks++;
        if (ack_total - a0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_ack_count: got %0d want 2", ack_total - a0);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        bit early_ack;
        early_ack = 0;
        c0 = cycle;
        wb_adr = 32'h104;
        wb_sel = 4'b1111;
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        while (cycle - c0 < 40) begin
            @(posedge clk);
            #1;
            if (wb_ack) early_ack = 1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_n: got %b want 1", spi_cs_n); end
        n_checks++;
        if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk: got %b want 0", spi_sclk); end
        n_checks++;
        if (wb_ack !== 1'b0 || early_ack) begin
            n_fail++;
            $display("FAIL rstmid_ack: got %b (early %0d) want 0", wb_ack, early_ack);
        end
        n_checks++;
        if (wb_rdt !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdt: got %h want 0", wb_rdt); end
        wb_cyc = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_read("rstmid_fresh", 32'h104, 8'h01, 8'h04, 32'h4433_2211);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h104] = 8'h11;
        mem[16'h105] = 8'h22;
        mem[16'h106] = 8'h33;
        mem[16'h107] = 8'h44;
        mem[16'h008] = 8'h5A;
        mem[16'h009] = 8'h6B;
        mem[16'h00A] = 8'h7C;
        mem[16'h00B] = 8'h8D;
        for (int i = 0; i < 4; i++) mem[16'h50 + 16'(i)] = 8'hA0 + 8'(i);

        test_reset();
        test_read("read", 32'h0000_0104, 8'h01, 8'h04, 32'h4433_2211);
        test_write("hw_write", 32'h10, 32'hAABB_CCDD, 4'b1100, 81);
        repeat (2) @(posedge clk);
        #1;
        test_write("byte_write", 32'h20, 32'h1234_5678, 4'b0010, 65);
        repeat (2) @(posedge clk);
        #1;
        test_empty_write();
        test_read("trunc_hi", 32'h8001_0008, 8'h00, 8'h08, 32'h8D7C_6B5A);
        test_read("trunc_lo", 32'h0000_0008, 8'h00, 8'h08, 32'h8D7C_6B5A);
        test_back_to_back();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
